// File: rtl/mic_capture_sequencer.sv
// rtl/mic_capture_sequencer.sv - capture/readout sequencer for the mic sample stores feeding xcorr
// Optional capture watchdog enabled by defining MIC_SEQ_TIMEOUT_EN.
module mic_capture_sequencer #(
  parameter int          ADDR_W      = 10,
  parameter logic [23:0] TIMEOUT_CYC = 24'd5_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trig,
  input  logic              abort,
  input  logic              store_busy,
  input  logic              xcorr_ready,
  output logic              cap_start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic              rd_last,
  output logic              frame_done,
  output logic              busy,
  output logic [7:0]        frame_cnt,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    CAPTURE,
    READ,
    DRAIN
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state;
  state_t            state_nxt;
  logic              start_nxt;
  logic              done_nxt;
  logic              last_nxt;
  logic              timeout_hit;
  logic [ADDR_W-1:0] addr_nxt;

`ifdef MIC_SEQ_TIMEOUT_EN
  logic [23:0] wdog;
  logic        err_q;

  // Fires on the TIMEOUT_CYC-th cycle spent waiting in ARM/CAPTURE.
  assign timeout_hit = ((state == ARM) || (state == CAPTURE)) &&
                       (wdog == (TIMEOUT_CYC - 24'd1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wdog  <= 24'd0;
      err_q <= 1'b0;
    end else begin
      if (start_nxt) begin
        wdog <= 24'd0;
      end else if ((state == ARM) || (state == CAPTURE)) begin
        wdog <= wdog + 24'd1;
      end

      if (start_nxt) begin
        err_q <= 1'b0;
      end else if (timeout_hit && !abort) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err = err_q;
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT_CYC;
  assign timeout_hit    = 1'b0;
  assign err            = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    start_nxt = 1'b0;
    done_nxt  = 1'b0;
    rd_en     = 1'b0;
    addr_nxt  = rd_addr;

    case (state)
      IDLE: begin
        if (trig) begin
          state_nxt = ARM;
          start_nxt = 1'b1;
        end
      end
      ARM: begin
        if (timeout_hit) begin
          state_nxt = IDLE;
        end else if (store_busy) begin
          state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        if (timeout_hit) begin
          state_nxt = IDLE;
        end else if (!store_busy) begin
          state_nxt = READ;
          addr_nxt  = '0;
        end
      end
      READ: begin
        rd_en = xcorr_ready;
        if (xcorr_ready) begin
          addr_nxt = rd_addr + ADDR_ONE;
          if (rd_addr == LAST_ADDR) begin
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Abort overrides everything, including a same-cycle trigger in IDLE.
    if (abort) begin
      state_nxt = IDLE;
      start_nxt = 1'b0;
      done_nxt  = 1'b0;
      rd_en     = 1'b0;
      addr_nxt  = '0;
    end
  end

  assign last_nxt = rd_en && (rd_addr == LAST_ADDR);
  assign busy     = (state != IDLE);

  // Store read latency is one cycle, so valid/last trail the enable by one register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_start  <= 1'b0;
      rd_addr    <= '0;
      rd_valid   <= 1'b0;
      rd_last    <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= 8'd0;
    end else begin
      cap_start  <= start_nxt;
      rd_addr    <= addr_nxt;
      rd_valid   <= rd_en;
      rd_last    <= last_nxt;
      frame_done <= done_nxt;
      if (done_nxt) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_mic_capture_sequencer.sv
// tb/tb_mic_capture_sequencer.sv - directed self-checking bench for mic_capture_sequencer
// Optional watchdog checks follow MIC_SEQ_TIMEOUT_EN.
module tb_mic_capture_sequencer;

  localparam int          AW         = 10;
  localparam int          NSAMP      = 1 << AW;
  localparam int          STORE_LEN  = 1024;
  localparam int          SMALL_LEN  = 3;
  localparam logic [23:0] TB_TIMEOUT = 24'd2000;

  logic          clk = 1'b0;
  logic          rst_n, trig, abort, store_busy, xcorr_ready;
  logic          cap_start, rd_en, rd_valid, rd_last, frame_done, busy, err;
  logic [AW-1:0] rd_addr;
  logic [7:0]    frame_cnt;

  logic          s_trig, s_store_busy;
  logic          s_cap_start, s_rd_en, s_rd_valid, s_rd_last, s_frame_done, s_busy, s_err;
  logic [1:0]    s_rd_addr;
  logic [7:0]    s_frame_cnt;

  logic store_stuck;
  int   store_cnt, s_store_cnt;
  int   n_pass = 0;
  int   n_total = 0;
  int   c_start, c_rden, c_bad, c_valid, c_last, c_last_idx, c_gap;
  bit   c_done;

  always #5 clk = ~clk;

  mic_capture_sequencer #(.ADDR_W(AW), .TIMEOUT_CYC(TB_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .trig(trig), .abort(abort), .store_busy(store_busy),
    .xcorr_ready(xcorr_ready), .cap_start(cap_start), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .rd_last(rd_last), .frame_done(frame_done), .busy(busy),
    .frame_cnt(frame_cnt), .err(err)
  );

  mic_capture_sequencer #(.ADDR_W(2), .TIMEOUT_CYC(24'd100)) u_small (
    .clk(clk), .rst_n(rst_n), .trig(s_trig), .abort(1'b0), .store_busy(s_store_busy),
    .xcorr_ready(1'b1), .cap_start(s_cap_start), .rd_en(s_rd_en), .rd_addr(s_rd_addr),
    .rd_valid(s_rd_valid), .rd_last(s_rd_last), .frame_done(s_frame_done), .busy(s_busy),
    .frame_cnt(s_frame_cnt), .err(s_err)
  );

  // Store models: busy rises one cycle after start, stays high for the frame length.
  always @(posedge clk) begin
    if (!rst_n) begin
      store_busy <= 1'b0;
      store_cnt  <= 0;
    end else if (cap_start && !store_stuck) begin
      store_busy <= 1'b1;
      store_cnt  <= STORE_LEN - 1;
    end else if (store_cnt > 0) begin
      store_cnt <= store_cnt - 1;
    end else begin
      store_busy <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      s_store_busy <= 1'b0;
      s_store_cnt  <= 0;
    end else if (s_cap_start) begin
      s_store_busy <= 1'b1;
      s_store_cnt  <= SMALL_LEN - 1;
    end else if (s_store_cnt > 0) begin
      s_store_cnt <= s_store_cnt - 1;
    end else begin
      s_store_busy <= 1'b0;
    end
  end

  // Pulses trig, runs one frame and tallies what the outputs did (no comparisons here).
  task automatic collect_frame(input int ready_mode, input int max_cyc);
    int exp_addr;
    int last_cyc;
    exp_addr = 0;
    last_cyc = -100;
    c_start = 0; c_rden = 0; c_bad = 0; c_valid = 0; c_last = 0;
    c_last_idx = -1; c_gap = -1; c_done = 0;
    for (int k = 0; k < max_cyc && !c_done; k++) begin
      @(negedge clk);
      trig        = (k == 0);
      xcorr_ready = (ready_mode == 0) ? 1'b1 : ((k % 4 == 0) || (k % 4 == 3));
      #1;
      if (cap_start) c_start++;
      if (rd_en && !xcorr_ready) c_bad++;
      if (rd_en) begin
        if (rd_addr !== exp_addr[AW-1:0]) c_bad++;
        exp_addr++;
        c_rden++;
      end
      if (rd_valid) begin
        c_valid++;
        if (rd_last) begin
          c_last++;
          c_last_idx = c_valid;
          last_cyc   = k;
        end
      end
      if (frame_done) begin
        c_done = 1;
        c_gap  = k - last_cyc;
      end
    end
    trig        = 1'b0;
    xcorr_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; trig = 1'b0; abort = 1'b0; xcorr_ready = 1'b0;
    store_stuck = 1'b0; s_trig = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_total++;
    if ({cap_start, rd_en, rd_valid, rd_last, frame_done, busy, err} !== 7'b0)
      $display("FAIL reset_flags: got %b want 0000000",
               {cap_start, rd_en, rd_valid, rd_last, frame_done, busy, err});
    else n_pass++;
    n_total++;
    if (rd_addr !== '0) $display("FAIL reset_rd_addr: got %0d want 0", rd_addr);
    else n_pass++;
    n_total++;
    if (frame_cnt !== 8'd0) $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    n_total++;
    if (busy !== 1'b0) $display("FAIL post_reset_busy: got %b want 0", busy);
    else n_pass++;
  endtask

  task automatic test_nominal();
    collect_frame(0, 2300);
    n_total++;
    if (c_done !== 1'b1) $display("FAIL nominal_done: got %0d want 1", c_done);
    else n_pass++;
    n_total++;
    if (c_start !== 1) $display("FAIL nominal_cap_start_cycles: got %0d want 1", c_start);
    else n_pass++;
    n_total++;
    if (c_rden !== NSAMP) $display("FAIL nominal_rd_en_count: got %0d want %0d", c_rden, NSAMP);
    else n_pass++;
    n_total++;
    if (c_bad !== 0) $display("FAIL nominal_addr_order: got %0d errors want 0", c_bad);
    else n_pass++;
    n_total++;
    if (c_last !== 1 || c_last_idx !== NSAMP)
      $display("FAIL nominal_rd_last: got count %0d idx %0d want 1 at %0d", c_last, c_last_idx, NSAMP);
    else n_pass++;
    n_total++;
    if (c_gap !== 1) $display("FAIL nominal_done_gap: got %0d want 1", c_gap);
    else n_pass++;
    n_total++;
    if (frame_cnt !== 8'd1) $display("FAIL nominal_frame_cnt: got %0d want 1", frame_cnt);
    else n_pass++;
    n_total++;
    if (busy !== 1'b0 || rd_addr !== '0)
      $display("FAIL nominal_end_idle: got busy %b addr %0d want 0 0", busy, rd_addr);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    collect_frame(1, 4000);
    n_total++;
    if (c_done !== 1'b1) $display("FAIL bp_done: got %0d want 1", c_done);
    else n_pass++;
    n_total++;
    if (c_rden !== NSAMP || c_valid !== NSAMP)
      $display("FAIL bp_beats: got rd_en %0d valid %0d want %0d", c_rden, c_valid, NSAMP);
    else n_pass++;
    n_total++;
    if (c_bad !== 0) $display("FAIL bp_addr_order: got %0d errors want 0", c_bad);
    else n_pass++;
    n_total++;
    if (c_last_idx !== NSAMP) $display("FAIL bp_rd_last: got %0d want %0d", c_last_idx, NSAMP);
    else n_pass++;
    n_total++;
    if (frame_cnt !== 8'd2) $display("FAIL bp_frame_cnt: got %0d want 2", frame_cnt);
    else n_pass++;
  endtask

  task automatic test_abort();
    int  n_done;
    bit  found;
    // abort during CAPTURE
    @(negedge clk); trig = 1'b1;
    @(negedge clk); trig = 1'b0;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (store_busy) found = 1;
    end
    repeat (20) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1;
    n_total++;
    if (found !== 1'b1 || busy !== 1'b0 || rd_addr !== '0 || cap_start !== 1'b0)
      $display("FAIL abort_capture_idle: got found %b busy %b addr %0d start %b want 1 0 0 0",
               found, busy, rd_addr, cap_start);
    else n_pass++;
    n_done = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      if (frame_done) n_done++;
    end
    n_total++;
    if (n_done !== 0 || frame_cnt !== 8'd2)
      $display("FAIL abort_capture_no_done: got done %0d cnt %0d want 0 2", n_done, frame_cnt);
    else n_pass++;
    for (int k = 0; k < 1100 && store_busy; k++) @(negedge clk);

    // abort while reading address 500
    found = 0;
    xcorr_ready = 1'b1;
    for (int k = 0; k < 2300 && !found; k++) begin
      @(negedge clk);
      trig = (k == 0);
      if (busy && rd_addr == 10'd500) begin
        abort = 1'b1;
        found = 1;
      end
      #1;
    end
    n_total++;
    if (found !== 1'b1 || rd_en !== 1'b0)
      $display("FAIL abort_read_rd_en: got found %b rd_en %b want 1 0", found, rd_en);
    else n_pass++;
    @(negedge clk);
    abort = 1'b0;
    #1;
    n_total++;
    if (busy !== 1'b0 || rd_addr !== '0 || rd_valid !== 1'b0)
      $display("FAIL abort_read_idle: got busy %b addr %0d valid %b want 0 0 0", busy, rd_addr, rd_valid);
    else n_pass++;
    n_done = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      if (frame_done) n_done++;
    end
    n_total++;
    if (n_done !== 0 || frame_cnt !== 8'd2)
      $display("FAIL abort_read_no_done: got done %0d cnt %0d want 0 2", n_done, frame_cnt);
    else n_pass++;

    collect_frame(0, 2300);
    n_total++;
    if (c_done !== 1'b1 || c_valid !== NSAMP || c_bad !== 0 || frame_cnt !== 8'd3)
      $display("FAIL abort_recover_frame: got done %0d valid %0d bad %0d cnt %0d want 1 %0d 0 3",
               c_done, c_valid, c_bad, frame_cnt, NSAMP);
    else n_pass++;
  endtask

  task automatic test_trig_filter();
    int n_start, n_done;
    n_start = 0;
    n_done  = 0;
    xcorr_ready = 1'b1;
    for (int k = 0; k < 5200; k++) begin
      @(negedge clk);
      trig = (k < 3000);
      #1;
      if (cap_start) n_start++;
      if (frame_done) n_done++;
    end
    n_total++;
    if (n_start !== 2) $display("FAIL trig_hold_starts: got %0d want 2", n_start);
    else n_pass++;
    n_total++;
    if (n_done !== 2 || frame_cnt !== 8'd5 || busy !== 1'b0)
      $display("FAIL trig_hold_frames: got done %0d cnt %0d busy %b want 2 5 0", n_done, frame_cnt, busy);
    else n_pass++;

    @(negedge clk);
    trig  = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    trig  = 1'b0;
    abort = 1'b0;
    #1;
    n_total++;
    if (cap_start !== 1'b0 || busy !== 1'b0)
      $display("FAIL trig_abort_idle: got start %b busy %b want 0 0", cap_start, busy);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int n_busy, n_err;
    n_busy = 0;
    n_err  = 0;
    store_stuck = 1'b1;
    @(negedge clk); trig = 1'b1;
    @(negedge clk); trig = 1'b0;
    #1;
    for (int k = 0; k < 3000; k++) begin
      if (!busy) break;
      n_busy++;
      if (err) n_err++;
      @(negedge clk);
      #1;
    end
`ifdef MIC_SEQ_TIMEOUT_EN
    n_total++;
    if (n_busy !== int'(TB_TIMEOUT) || n_err !== 0)
      $display("FAIL timeout_cycles: got busy %0d err %0d want %0d 0", n_busy, n_err, TB_TIMEOUT);
    else n_pass++;
    n_total++;
    if (err !== 1'b1 || frame_done !== 1'b0)
      $display("FAIL timeout_err_set: got err %b done %b want 1 0", err, frame_done);
    else n_pass++;
    @(negedge clk); trig = 1'b1;
    @(negedge clk); trig = 1'b0;
    #1;
    n_total++;
    if (err !== 1'b0 || busy !== 1'b1)
      $display("FAIL timeout_err_clear: got err %b busy %b want 0 1", err, busy);
    else n_pass++;
`else
    n_total++;
    if (n_busy !== 3000 || n_err !== 0)
      $display("FAIL no_timeout_wait: got busy %0d err %0d want 3000 0", n_busy, n_err);
    else n_pass++;
`endif
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    #1;
    store_stuck = 1'b0;
    n_total++;
    if (busy !== 1'b0 || frame_cnt !== 8'd5)
      $display("FAIL timeout_abort_idle: got busy %b cnt %0d want 0 5", busy, frame_cnt);
    else n_pass++;
  endtask

  task automatic test_wrap();
    int n_done, n_bad, cnt_at_last;
    n_done = 0;
    n_bad  = 0;
    cnt_at_last = -1;
    s_trig = 1'b1;
    for (int k = 0; k < 8000 && n_done < 256; k++) begin
      @(negedge clk);
      #1;
      if (s_frame_done) begin
        n_done++;
        if (int'(s_frame_cnt) !== (n_done % 256)) n_bad++;
        if (n_done == 256) cnt_at_last = int'(s_frame_cnt);
      end
    end
    s_trig = 1'b0;
    n_total++;
    if (n_done !== 256) $display("FAIL wrap_frames: got %0d want 256", n_done);
    else n_pass++;
    n_total++;
    if (n_bad !== 0) $display("FAIL wrap_count_seq: got %0d errors want 0", n_bad);
    else n_pass++;
    n_total++;
    if (cnt_at_last !== 0) $display("FAIL wrap_to_zero: got %0d want 0", cnt_at_last);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_abort();
    test_trig_filter();
    test_timeout();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
